// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display scan controller.
package display_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int SEL_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Scan controller signal bundle: enable/mask in, mux select and digit enables out.
interface display_scan_ctrl_if
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = MAX_DIGITS
);
    logic                  enable;
    logic [NUM_DIGITS-1:0] digit_mask;
    logic [SEL_W-1:0]      select;
    logic [NUM_DIGITS-1:0] digit_en_n;
    logic                  blank;
    logic                  frame_start;

    modport master (
        output enable, digit_mask,
        input  select, digit_en_n, blank, frame_start
    );

    modport slave (
        input  enable, digit_mask,
        output select, digit_en_n, blank, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl_next_digit_finder.sv
// Wrap-around priority search for the next participating digit.
// Falls back to the lowest set bit when nothing above cur is set (wrap).
module next_digit_finder
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = MAX_DIGITS
) (
    input  logic [SEL_W-1:0]      cur,
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic                  from_lowest,
    output logic [SEL_W-1:0]      next_idx,
    output logic                  wrapped
);
    logic [SEL_W-1:0]      hi_idx;
    logic [SEL_W-1:0]      lo_idx;
    logic                  hi_found;
    logic [NUM_DIGITS-1:0] sh;

    always_comb begin
        hi_idx   = cur;
        lo_idx   = cur;
        hi_found = 1'b0;
        sh       = '0;
        // Descending scan so the last hit is the lowest qualifying index.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            sh = mask >> i;
            if (sh[0]) begin
                lo_idx = SEL_W'(i);
                if (!from_lowest && (i > int'(cur))) begin
                    hi_idx   = SEL_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        next_idx = hi_found ? hi_idx : lo_idx;
        wrapped  = !from_lowest && !hi_found && (|mask);
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan: each PRESCALE-cycle slot is BLANK_CYCLES
// of all-off followed by the selected digit enabled.
//
// state | meaning
// IDLE  | scan stopped, all digits off
// BLANK | start of slot, select already moved, all digits off
// SHOW  | digit_en_n[select] low until the slot ends
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic              clk,
    input  logic              reset_n,
    display_scan_ctrl_if.slave scan
);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);

    scan_state_e           state_q;
    logic [SEL_W-1:0]      select_q;
    logic [NUM_DIGITS-1:0] digit_en_n_q;
    logic                  blank_q;
    logic                  frame_start_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [SEL_W-1:0]      nxt_idx;
    logic                  nxt_wrapped;
    logic [NUM_DIGITS-1:0] mask_sh;
    logic                  cur_bit;
    logic [NUM_DIGITS-1:0] onehot;

    next_digit_finder #(.NUM_DIGITS(NUM_DIGITS)) u_finder (
        .cur         (select_q),
        .mask        (scan.digit_mask),
        .from_lowest (state_q == ST_IDLE),
        .next_idx    (nxt_idx),
        .wrapped     (nxt_wrapped)
    );

    assign mask_sh = scan.digit_mask >> select_q;
    assign cur_bit = mask_sh[0];
    assign onehot  = NUM_DIGITS'(1) << select_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            select_q      <= '0;
            digit_en_n_q  <= '1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            frame_start_q <= 1'b0;
            if (!scan.enable) begin
                state_q      <= ST_IDLE;
                digit_en_n_q <= '1;
                blank_q      <= 1'b1;
                cnt_q        <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        digit_en_n_q <= '1;
                        blank_q      <= 1'b1;
                        if (|scan.digit_mask) begin
                            state_q       <= ST_BLANK;
                            select_q      <= nxt_idx;
                            cnt_q         <= '0;
                            frame_start_q <= 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == BLANK_LAST) begin
                            state_q <= ST_SHOW;
                            // A digit whose mask bit is already gone stays dark.
                            if (cur_bit) begin
                                digit_en_n_q <= ~onehot;
                                blank_q      <= 1'b0;
                            end
                        end
                    end
                    ST_SHOW: begin
                        if (cnt_q == SLOT_LAST) begin
                            digit_en_n_q <= '1;
                            blank_q      <= 1'b1;
                            cnt_q        <= '0;
                            if (|scan.digit_mask) begin
                                state_q       <= ST_BLANK;
                                select_q      <= nxt_idx;
                                frame_start_q <= nxt_wrapped;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (!cur_bit) begin
                                digit_en_n_q <= '1;
                                blank_q      <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign scan.select      = select_q;
    assign scan.digit_en_n  = digit_en_n_q;
    assign scan.blank       = blank_q;
    assign scan.frame_start = frame_start_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;
    import display_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   seq[8];
    int   seq_len;

    display_scan_ctrl_if #(.NUM_DIGITS(8)) s8 ();
    display_scan_ctrl_if #(.NUM_DIGITS(4)) s4 ();

    display_scan_ctrl #(.NUM_DIGITS(8), .PRESCALE(8), .BLANK_CYCLES(2)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .scan    (s8.slave)
    );

    display_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .scan    (s4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // k=0 is the first cycle of the first BLANK; slot = 8 cycles, 2 blank + 6 show.
    task automatic scan_frames(input string name, input int ncycles);
        int         ph;
        int         si;
        logic [2:0] es;
        logic [7:0] een;
        logic       eb;
        logic       efs;
        for (int k = 0; k < ncycles; k++) begin
            ph  = k % 8;
            si  = (k / 8) % seq_len;
            es  = 3'(seq[si]);
            eb  = (ph < 2);
            een = eb ? 8'hFF : ~(8'h01 << es);
            efs = (ph == 0) && (si == 0);
            check($sformatf("%s_k%0d", name, k),
                  32'({s8.select, s8.digit_en_n, s8.blank, s8.frame_start}),
                  32'({es, een, eb, efs}));
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        s8.enable = 1'b0;
        s8.digit_mask = '0;
        s4.enable = 1'b0;
        s4.digit_mask = '0;
        repeat (2) @(negedge clk);

        check("reset_outputs", 32'({s8.select, s8.digit_en_n, s8.blank, s8.frame_start}),
              32'({3'd0, 8'hFF, 1'b1, 1'b0}));
        check("reset_state", 32'(dut8.state_q), 32'(ST_IDLE));
        check("reset_cnt", 32'(dut8.cnt_q), 32'd0);

        // Full mask: 0..7 then wrap, frame every 64 cycles.
        do_reset();
        s8.digit_mask = 8'hFF;
        s8.enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) seq[i] = i;
        seq_len = 8;
        scan_frames("mask_ff", 66);

        // Sparse mask 1000_0101: 0,2,7 with a 24-cycle frame.
        do_reset();
        s8.digit_mask = 8'b1000_0101;
        @(negedge clk);
        seq[0] = 0; seq[1] = 2; seq[2] = 7;
        seq_len = 3;
        scan_frames("mask_85", 50);

        // Single digit: frame_start each slot.
        do_reset();
        s8.digit_mask = 8'b0001_0000;
        @(negedge clk);
        seq[0] = 4;
        seq_len = 1;
        scan_frames("mask_10", 26);

        // Drop digit 3's mask bit mid-SHOW.
        do_reset();
        s8.digit_mask = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 8; i++) seq[i] = i;
        seq_len = 8;
        scan_frames("pre_drop", 27);
        check("drop_k27_shown", 32'({s8.digit_en_n, s8.blank}), 32'({8'hF7, 1'b0}));
        s8.digit_mask = 8'hF7;
        @(negedge clk);
        check("drop_k28_off", 32'({s8.digit_en_n, s8.blank}), 32'({8'hFF, 1'b1}));
        repeat (3) @(negedge clk);
        check("drop_k31_off", 32'({s8.select, s8.digit_en_n, s8.blank}), 32'({3'd3, 8'hFF, 1'b1}));
        @(negedge clk);
        check("drop_k32_next", 32'({s8.select, s8.digit_en_n, s8.blank}), 32'({3'd4, 8'hFF, 1'b1}));
        repeat (2) @(negedge clk);
        check("drop_k34_show4", 32'({s8.select, s8.digit_en_n, s8.blank}), 32'({3'd4, 8'hEF, 1'b0}));

        // Reset for one cycle during SHOW of digit 2 (k=20).
        do_reset();
        s8.digit_mask = 8'hFF;
        @(negedge clk);
        repeat (20) @(negedge clk);
        check("pre_rst_show2", 32'({s8.select, s8.digit_en_n}), 32'({3'd2, 8'hFB}));
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", 32'({s8.select, s8.digit_en_n, s8.blank, s8.frame_start}),
              32'({3'd0, 8'hFF, 1'b1, 1'b0}));
        check("midrst_state", 32'(dut8.state_q), 32'(ST_IDLE));
        reset_n = 1'b1;
        @(negedge clk);
        check("after_rst_restart", 32'({s8.select, s8.blank, s8.frame_start}), 32'({3'd0, 1'b1, 1'b1}));

        // enable=0 during BLANK of digit 1 (k=8): select holds.
        do_reset();
        @(negedge clk);
        repeat (8) @(negedge clk);
        check("pre_dis_blank1", 32'({s8.select, s8.blank, s8.digit_en_n}), 32'({3'd1, 1'b1, 8'hFF}));
        s8.enable = 1'b0;
        @(negedge clk);
        check("dis_outputs", 32'({s8.select, s8.digit_en_n, s8.blank, s8.frame_start}),
              32'({3'd1, 8'hFF, 1'b1, 1'b0}));
        check("dis_state", 32'(dut8.state_q), 32'(ST_IDLE));
        repeat (4) @(negedge clk);
        check("dis_hold_idle", 32'({s8.digit_en_n, s8.blank, 30'(dut8.state_q)}),
              32'({8'hFF, 1'b1, 30'(ST_IDLE)}));

        // Empty mask with enable=1 never starts a frame.
        do_reset();
        s8.digit_mask = 8'h00;
        s8.enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("mask0_k%0d", k), 32'({s8.digit_en_n, s8.blank, s8.frame_start}),
                  32'({8'hFF, 1'b1, 1'b0}));
        end
        check("mask0_state", 32'(dut8.state_q), 32'(ST_IDLE));
        s8.enable = 1'b0;

        // Four-digit build: 0..3 only, frame every 32 cycles.
        do_reset();
        s4.digit_mask = 4'hF;
        s4.enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 34; k++) begin
            logic [2:0] es;
            logic [3:0] een;
            logic       eb;
            logic       efs;
            es  = 3'((k / 8) % 4);
            eb  = ((k % 8) < 2);
            een = eb ? 4'hF : ~(4'h1 << es);
            efs = ((k % 8) == 0) && (es == 3'd0);
            check($sformatf("n4_k%0d", k), 32'({s4.select, s4.digit_en_n, s4.blank, s4.frame_start}),
                  32'({es, een, eb, efs}));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
